// File: rtl/prefix_adder_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
// Ops are numbered pre=0, prefix level k = k+1, post = levels+1.
package prefix_adder_pipe_pkg;

    localparam int MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } result_t;

    function automatic int num_levels(input int width);
        return $clog2(width);
    endfunction

    // Stage s covers ops [stage_end(s-1), stage_end(s)); integer division spreads them evenly.
    function automatic int stage_end(input int s, input int nops, input int stages);
        return (s + 1) * nops / stages;
    endfunction

    // Index of the stage whose register sits right after op, or -1 if op output is not registered.
    function automatic int cut_stage(input int op, input int nops, input int stages);
        int r;
        r = -1;
        for (int s = 0; s < stages - 1; s++)
            if (stage_end(s, nops, stages) - 1 == op) r = s;
        return r;
    endfunction

endpackage

// File: rtl/prefix_adder_pipe_level.sv
// One Kogge-Stone prefix level: black cells for bits >= DIST, pass-through below.
module prefix_level #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_cell
            assign g_out[i] = g[i] | (p[i] & g[i-DIST]);
            assign p_out[i] = p[i] & p[i-DIST];
        end else begin : g_pass
            assign g_out[i] = g[i];
            assign p_out[i] = p[i];
        end
    end
endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone add/sub with valid/ready flow control.
// Carry-in is folded into bit 0 generate so the prefix tree yields every carry directly.
module prefix_adder_pipe
    import prefix_adder_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int LVLS = num_levels(WIDTH);
    localparam int NOPS = LVLS + 2;
    localparam int NW   = 3 * WIDTH + 1;  // {p0, G, P, carry_in}

    logic [STAGES-1:0] vld, adv, vld_src;
    logic [NW-1:0]     nd_d [LVLS+1];
    logic [NW-1:0]     nd_q [LVLS+1];

    // A stage moves when every stage from it to the output is full only if the output drains.
    for (genvar s = 0; s < STAGES; s++) begin : g_adv
        assign adv[s] = out_ready || !(&vld[STAGES-1:s]);
    end

    assign vld_src   = STAGES'({vld, in_valid});
    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld <= '0;
        else
            for (int s = 0; s < STAGES; s++)
                if (adv[s]) vld[s] <= vld_src[s];
    end

    logic [WIDTH-1:0] bx, p0, g0;
    logic             c0;

    assign bx = sub ? ~b : b;
    assign c0 = sub | cin;
    assign p0 = a ^ bx;
    assign g0 = a & bx;
    assign nd_d[0] = {p0, g0 | {{(WIDTH-1){1'b0}}, p0[0] & c0}, p0, c0};

    for (genvar k = 0; k < LVLS; k++) begin : g_lvl
        logic [WIDTH-1:0] pk, gi, pi, go, po;
        logic             ck;
        assign {pk, gi, pi, ck} = nd_q[k];
        prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_level (
            .g(gi), .p(pi), .g_out(go), .p_out(po)
        );
        assign nd_d[k+1] = {pk, go, po, ck};
    end

    for (genvar j = 0; j <= LVLS; j++) begin : g_node
        if (cut_stage(j, NOPS, STAGES) >= 0) begin : g_reg
            localparam int SI = cut_stage(j, NOPS, STAGES);
            logic [NW-1:0] r;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      r <= '0;
                else if (adv[SI]) r <= nd_d[j];
            end
            assign nd_q[j] = r;
        end else begin : g_wire
            assign nd_q[j] = nd_d[j];
        end
    end

    logic [WIDTH-1:0] pf, gf, pf_grp_unused, s_w;
    logic             cf;
    result_t          res_d, res_q;

    assign {pf, gf, pf_grp_unused, cf} = nd_q[LVLS];
    assign s_w = pf ^ {gf[WIDTH-2:0], cf};

    always_comb begin
        res_d      = '0;
        res_d.sum  = MAX_W'(s_w);
        res_d.cout = gf[WIDTH-1];
        res_d.ovf  = gf[WIDTH-1] ^ gf[WIDTH-2];
        res_d.zero = ~|s_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                res_q <= '0;
        else if (adv[STAGES-1])    res_q <= res_d;
    end

    if (WIDTH < MAX_W) begin : g_pad
        logic pad_unused;
        assign pad_unused = |res_q.sum[MAX_W-1:WIDTH];
    end

    assign sum  = res_q.sum[WIDTH-1:0];
    assign cout = res_q.cout;
    assign ovf  = res_q.ovf;
    assign zero = res_q.zero;
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench: main 32-bit/2-stage instance plus 4-bit/1-stage and 64-bit/7-stage sweeps.
module tb_prefix_adder_pipe;
    localparam int W = 32, S = 2;

    typedef struct packed { logic [63:0] sum; logic cout, ovf, zero; } res_t;
    typedef struct { res_t r; int cyc; } exp_t;
    typedef struct {
        logic [W-1:0] a, b; logic cin, sub;
        logic [W-1:0] sum; logic cout, ovf, zero;
    } vec_t;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic lat_chk = 0;

    logic in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 1, cout, ovf, zero;
    logic [W-1:0] a = 0, b = 0, sum;
    prefix_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero));

    logic v4 = 0, r4, c4 = 0, s4 = 0, ov4, or4 = 1, co4, of4, z4;
    logic [3:0] a4 = 0, b4 = 0, sum4;
    prefix_adder_pipe #(.WIDTH(4), .STAGES(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
        .cin(c4), .sub(s4), .out_valid(ov4), .out_ready(or4), .sum(sum4),
        .cout(co4), .ovf(of4), .zero(z4));

    logic v64 = 0, r64, c64 = 0, s64 = 0, ov64, or64 = 1, co64, of64, z64;
    logic [63:0] a64 = 0, b64 = 0, sum64;
    prefix_adder_pipe #(.WIDTH(64), .STAGES(7)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .a(a64), .b(b64),
        .cin(c64), .sub(s64), .out_valid(ov64), .out_ready(or64), .sum(sum64),
        .cout(co64), .ovf(of64), .zero(z64));

    exp_t q[$], q4[$], q64[$];

    task automatic chk(input string nm, input logic [66:0] got, input logic [66:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic res_t model(input int w, input logic [63:0] x, y, input logic ci, sb);
        res_t m; logic [64:0] r; logic [63:0] mask, yy;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        yy   = (sb ? ~y : y) & mask;
        r    = {1'b0, x & mask} + {1'b0, yy} + 65'(sb ? 1'b1 : ci);
        m.sum  = r[63:0] & mask;
        m.cout = r[w];
        m.ovf  = (x[w-1] == yy[w-1]) && (m.sum[w-1] != x[w-1]);
        m.zero = (m.sum == 64'd0);
        return m;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) q.delete();
        else if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected beat", out_valid, 0);
            else begin
                e = q.pop_front();
                chk("w32 result", {64'(sum), cout, ovf, zero}, e.r);
                if (lat_chk) chk("w32 latency", cyc - e.cyc, S);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) q4.delete();
        else if (ov4) begin
            if (q4.size() == 0) chk("w4 unexpected", ov4, 0);
            else begin
                e = q4.pop_front();
                chk("w4 result", {64'(sum4), co4, of4, z4}, e.r);
                chk("w4 latency", cyc - e.cyc, 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) q64.delete();
        else if (ov64) begin
            if (q64.size() == 0) chk("w64 unexpected", ov64, 0);
            else begin
                e = q64.pop_front();
                chk("w64 result", {sum64, co64, of64, z64}, e.r);
                chk("w64 latency", cyc - e.cyc, 7);
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, tb, input logic tc, ts, input res_t er);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k == 0 && lat_chk) chk("stream ready", in_ready, 1);
            if (in_ready) begin
                q.push_back('{r: er, cyc: cyc});
                @(posedge clk); #1;
                in_valid = 0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("accept timeout", in_ready, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        int k;
        in_valid = 0;
        k = 0;
        while (k < 200 && (q.size() > 0 || q4.size() > 0 || q64.size() > 0)) begin
            @(posedge clk); k++;
        end
        #1;
        chk("drain", q.size() + q4.size() + q64.size(), 0);
    endtask

    initial begin
        vec_t tbl[10];
        logic [W-1:0] ra, rb;
        logic rc, rs, held;
        res_t hold_r;
        int nacc, stale;

        tbl[0] = '{32'hFFFFFFFF, 32'h1,        0, 0, 32'h0,        1, 0, 1};
        tbl[1] = '{32'h80000000, 32'h1,        0, 1, 32'h7FFFFFFF, 1, 1, 0};
        tbl[2] = '{32'h7FFFFFFF, 32'h1,        0, 0, 32'h80000000, 0, 1, 0};
        tbl[3] = '{32'h0,        32'h0,        1, 0, 32'h1,        0, 0, 0};
        tbl[4] = '{32'h5,        32'h5,        0, 1, 32'h0,        1, 0, 1};
        tbl[5] = '{32'h3,        32'h5,        0, 1, 32'hFFFFFFFE, 0, 0, 0};
        tbl[6] = '{32'hA,        32'h3,        1, 1, 32'h7,        1, 0, 0};
        tbl[7] = '{32'h80000000, 32'h80000000, 0, 0, 32'h0,        1, 1, 1};
        tbl[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0};
        tbl[9] = '{32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0, 0};

        #12;
        chk("rst out_valid", {out_valid, ov4, ov64}, 0);
        chk("rst sum", sum, 0);
        chk("rst flags", {cout, ovf, zero}, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("ready after rst", in_ready, 1);
        @(posedge clk); #1;

        lat_chk = 1;
        for (int i = 0; i < 10; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                 '{64'(tbl[i].sum), tbl[i].cout, tbl[i].ovf, tbl[i].zero});
        for (int i = 0; i < 100; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = ($urandom_range(0, 3) == 0);
            if (i % 17 == 0) rb = rs ? ra : -ra;
            send(ra, rb, rc, rs, model(W, 64'(ra), 64'(rb), rc, rs));
        end
        drain();

        // Back-pressure: pipeline fills to STAGES beats and holds its outputs.
        lat_chk = 0; out_ready = 0; nacc = 0; held = 0; hold_r = '0;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom; rb = $urandom;
            a = ra; b = rb; cin = 0; sub = i[0]; in_valid = 1;
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{r: model(W, 64'(ra), 64'(rb), 1'b0, i[0]), cyc: cyc});
                nacc++;
            end
            if (out_valid) begin
                if (!held) begin hold_r = {64'(sum), cout, ovf, zero}; held = 1; end
                else chk("stall hold", {64'(sum), cout, ovf, zero}, hold_r);
            end
            @(posedge clk); #1;
        end
        chk("stall accepts", nacc, S);
        chk("stall in_ready", in_ready, 0);
        chk("stall out_valid", out_valid, 1);
        in_valid = 0;
        out_ready = 1; #1;
        chk("full pass ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            send(ra, rb, 1'b1, 1'b0, model(W, 64'(ra), 64'(rb), 1'b1, 1'b0));
        end
        drain();

        // Reset with two beats in flight.
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            ra = $urandom; rb = $urandom;
            send(ra, rb, 1'b0, 1'b0, model(W, 64'(ra), 64'(rb), 1'b0, 1'b0));
        end
        @(posedge clk); #2;
        chk("pre-rst out_valid", out_valid, 1);
        rst_n = 0; #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst sum", {sum, cout, ovf, zero}, 0);
        q.delete();
        @(posedge clk); #1 rst_n = 1; out_ready = 1;
        stale = 0;
        repeat (8) begin @(negedge clk); if (out_valid) stale++; end
        chk("no stale beat", stale, 0);
        @(posedge clk); #1;

        // 4-bit exhaustive (add with cin 0/1, then sub), streamed.
        for (int i = 0; i < 768; i++) begin
            a4 = i[3:0]; b4 = i[7:4]; s4 = (i >= 512);
            c4 = s4 ? 1'($urandom) : i[8];
            v4 = 1;
            @(negedge clk);
            chk("w4 ready", r4, 1);
            q4.push_back('{r: model(4, 64'(a4), 64'(b4), c4, s4), cyc: cyc});
            @(posedge clk); #1;
        end
        v4 = 0;

        // 64-bit random, streamed through the deepest split.
        for (int i = 0; i < 150; i++) begin
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            if (i % 10 == 0) b64 = ~a64;
            c64 = 1'($urandom); s64 = 1'($urandom); v64 = 1;
            @(negedge clk);
            chk("w64 ready", r64, 1);
            q64.push_back('{r: model(64, a64, b64, c64, s64), cyc: cyc});
            @(posedge clk); #1;
        end
        v64 = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
